// File: rtl/mux_arb_reg_pkg.sv
// Shared constants for the selectable-source output register.
// Mode encodings used by mux_arb_reg and its testbench.
package mux_arb_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Wrap-around priority picker: first set request at or after start.
// Purely combinational; start must be below N.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         grant_valid,
  output logic [W-1:0] grant
);

  logic [W:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (W+1)'(k);
      // explicit wrap keeps non-power-of-2 N correct
      if (idx >= (W+1)'(N)) begin
        idx = idx - (W+1)'(N);
      end
      if (!grant_valid && req[idx[W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-way valid/ready source select into a single-entry output register.
// Fixed (external selector) or round-robin grant.
module mux_arb_reg
  import mux_arb_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             Mode,
  input  logic [SEL_WIDTH-1:0]             Selector,
  input  logic [NUM_INPUTS-1:0]            In_Valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] In_Data,
  output logic [NUM_INPUTS-1:0]            In_Ready,
  output logic                             Out_Valid,
  output logic [DATA_WIDTH-1:0]            Out_Data,
  output logic [SEL_WIDTH-1:0]             Out_Sel,
  input  logic                             Out_Ready
);

  localparam int PAD = 1 << SEL_WIDTH;

  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  rr_grant;
  logic [SEL_WIDTH-1:0]  grant;
  logic [SEL_WIDTH-1:0]  ptr_next;
  logic                  rr_valid;
  logic                  grant_valid;
  logic                  can_accept;
  logic                  xfer;
  logic [PAD-1:0]        valid_pad;
  logic [DATA_WIDTH-1:0] grant_data;

  // zero padding makes out-of-range selectors read as invalid
  assign valid_pad = PAD'(In_Valid);

  rr_priority_pick #(
    .N (NUM_INPUTS),
    .W (SEL_WIDTH)
  ) u_pick (
    .req         (In_Valid),
    .start       (rr_ptr),
    .grant_valid (rr_valid),
    .grant       (rr_grant)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    unique case (1'b1)
      (Mode == MODE_RR): begin
        grant_valid = rr_valid;
        grant       = rr_grant;
      end
      default: begin
        grant_valid = valid_pad[Selector];
        grant       = Selector;
      end
    endcase
  end

  assign can_accept = !Out_Valid || Out_Ready;
  assign xfer       = !reset && can_accept && grant_valid;
  assign In_Ready   = xfer ? (NUM_INPUTS'(1) << grant) : '0;
  assign grant_data = In_Data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_next   = (grant == SEL_WIDTH'(NUM_INPUTS-1))
                    ? '0 : grant + SEL_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Sel   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      Out_Valid <= 1'b1;
      Out_Data  <= grant_data;
      Out_Sel   <= grant;
      if (Mode == MODE_RR) begin
        rr_ptr <= ptr_next;
      end
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg (4-input and 3-input builds).
// Reference model tracks the output register and round-robin pointer.
module tb_mux_arb_reg;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int DW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;
  logic          out_ready;

  logic          mode3;
  logic [SW-1:0] sel3;
  logic [N3-1:0] in_valid3;
  logic [N3-1:0] in_ready3;
  logic [N3*DW-1:0] in_data3;
  logic          out_valid3;
  logic [DW-1:0] out_data3;
  logic [SW-1:0] out_sel3;
  logic          out_ready3;

  int vectors     = 0;
  int miscompares = 0;

  bit            m_valid = 0;
  logic [DW-1:0] m_data  = '0;
  int            m_sel   = 0;
  int            m_ptr   = 0;

  always #5 clk = ~clk;

  mux_arb_reg #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .Mode(mode), .Selector(sel),
    .In_Valid(in_valid), .In_Data(in_data), .In_Ready(in_ready),
    .Out_Valid(out_valid), .Out_Data(out_data), .Out_Sel(out_sel),
    .Out_Ready(out_ready)
  );

  mux_arb_reg #(.DATA_WIDTH(DW), .NUM_INPUTS(N3)) dut3 (
    .clk(clk), .reset(reset), .Mode(mode3), .Selector(sel3),
    .In_Valid(in_valid3), .In_Data(in_data3), .In_Ready(in_ready3),
    .Out_Valid(out_valid3), .Out_Data(out_data3), .Out_Sel(out_sel3),
    .Out_Ready(out_ready3)
  );

  // winning channel for the 4-input build, -1 when nobody is granted
  function automatic int pick(bit md, int s, logic [N-1:0] v, int ptr);
    if (!md) return v[s] ? s : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick(mode, int'(sel), in_valid, m_ptr);
    if (reset || g < 0 || (m_valid && !out_ready)) return '0;
    return N'(1) << g;
  endfunction

  task automatic tick();
    int g;
    bit x;
    logic [DW-1:0] d;
    g = pick(mode, int'(sel), in_valid, m_ptr);
    x = !reset && g >= 0 && (!m_valid || out_ready);
    d = (g >= 0) ? in_data[g*DW +: DW] : '0;
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (x) begin
      m_valid = 1; m_data = d; m_sel = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++) in_data[c*DW +: DW] = $urandom;
    for (int c = 0; c < N3; c++) in_data3[c*DW +: DW] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1; mode = 1; sel = '0; in_valid = 4'hF; out_ready = 1;
    mode3 = 1; sel3 = '0; in_valid3 = 3'b111; out_ready3 = 1;
    for (int i = 0; i < 2; i++) begin
      rand_data();
      #1;
      vectors++;
      if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_ready got %b/%b want 0000/000", in_ready, in_ready3);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_out got v=%b d=%h s=%0d want v=0 d=0 s=0",
                 out_valid, out_data, out_sel);
      end
    end
    reset = 0; in_valid = '0; in_valid3 = '0;
  endtask

  task automatic test_fixed();
    logic [DW-1:0] d;
    mode = 0; sel = 2'd2; in_valid = 4'hF; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      d = (i == 0) ? 32'hDEADBEEF : DW'($urandom);
      in_data[2*DW +: DW] = d;
      #1;
      vectors++;
      if (in_ready !== 4'b0100) begin
        miscompares++;
        $display("FAIL fixed_ready got %b want 0100", in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d || out_sel !== 2'd2) begin
        miscompares++;
        $display("FAIL fixed_out got v=%b d=%h s=%0d want v=1 d=%h s=2",
                 out_valid, out_data, out_sel, d);
      end
    end
  endtask

  task automatic test_rr_fairness();
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    mode = 1; in_valid = 4'b1011; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      #1;
      vectors++;
      if (in_ready !== (N'(1) << seq[i])) begin
        miscompares++;
        $display("FAIL rr_ready[%0d] got %b want ch %0d", i, in_ready, seq[i]);
      end
      tick();
      vectors++;
      if (out_sel !== SW'(seq[i]) || out_data !== m_data) begin
        miscompares++;
        $display("FAIL rr_seq[%0d] got s=%0d d=%h want s=%0d d=%h",
                 i, out_sel, out_data, seq[i], m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1; in_valid = 4'b0010; out_ready = 1;
    rand_data();
    in_data[1*DW +: DW] = 32'h00000011;
    tick();
    vectors++;
    if (out_sel !== 2'd1 || out_data !== 32'h11) begin
      miscompares++;
      $display("FAIL bp_load got s=%0d d=%h want s=1 d=00000011", out_sel, out_data);
    end
    out_ready = 0; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      #1;
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_ready got %b want 0000", in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 || out_sel !== 2'd1) begin
        miscompares++;
        $display("FAIL bp_hold got v=%b d=%h s=%0d want v=1 d=00000011 s=1",
                 out_valid, out_data, out_sel);
      end
    end
    out_ready = 1;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_release got %b want 0100", in_ready);
    end
    tick();
    vectors++;
    if (out_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_next got s=%0d want 2", out_sel);
    end
  endtask

  task automatic test_edge3();
    int seq [4] = '{0, 1, 2, 0};
    out_ready3 = 1; mode3 = 0; sel3 = 2'd3; in_valid3 = 3'b111;
    rand_data();
    #1;
    vectors++;
    if (in_ready3 !== 3'b000) begin
      miscompares++;
      $display("FAIL e3_oor_ready got %b want 000", in_ready3);
    end
    tick();
    vectors++;
    if (out_valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL e3_oor_out got v=%b want 0", out_valid3);
    end
    sel3 = 2'd1; in_valid3 = 3'b101;
    #1;
    vectors++;
    if (in_ready3 !== 3'b000) begin
      miscompares++;
      $display("FAIL e3_inv_ready got %b want 000", in_ready3);
    end
    tick();
    vectors++;
    if (out_valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL e3_inv_out got v=%b want 0", out_valid3);
    end
    mode3 = 1; in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      tick();
      vectors++;
      if (out_valid3 !== 1'b1 || out_sel3 !== SW'(seq[i])) begin
        miscompares++;
        $display("FAIL e3_wrap[%0d] got v=%b s=%0d want v=1 s=%0d",
                 i, out_valid3, out_sel3, seq[i]);
      end
    end
    in_valid3 = '0;
  endtask

  task automatic test_reset_mid_stall();
    mode = 1; in_valid = 4'hF; out_ready = 0;
    rand_data();
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_stall_pre got v=%b want 1", out_valid);
    end
    reset = 1;
    #1;
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_stall_ready got %b want 0000", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_stall_out got v=%b d=%h s=%0d want v=0 d=0 s=0",
               out_valid, out_data, out_sel);
    end
    reset = 0; out_ready = 1;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_stall_grant got %b want 0001", in_ready);
    end
    tick();
    vectors++;
    if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_stall_next got v=%b s=%0d want v=1 s=0", out_valid, out_sel);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      #1;
      er = exp_ready();
      vectors++;
      if (in_ready !== er) begin
        miscompares++;
        $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, er);
      end
      tick();
      vectors++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== SW'(m_sel)) begin
        miscompares++;
        $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_backpressure();
    test_edge3();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
